// File: rtl/inst_enc.sv
// inst_enc: packs RISC-V instruction fields into 32-bit words and streams them to instruction memory.
// Optional feature: define INST_ENC_CSUM_EN to keep a running XOR checksum of written words.
module inst_enc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] count,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] csum
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;

    logic [1:0]  state;
    logic [15:0] remaining;
    logic [31:0] addr;
    logic [31:0] word;
    logic        legal;
    logic        xfer;
    logic        base_unused;

    // Low address bits are forced to zero, so they are never consumed.
    assign base_unused = ^base_addr[1:0];

    assign in_ready = (state == LOAD) && (remaining != 16'd0);
    assign xfer     = in_valid && in_ready;
    assign legal    = fmt <= 3'd5;
    assign busy     = state != IDLE;
    assign done     = state == DONE;

    // Assemble the instruction word for the presented format; J is the fall-through.
    always_comb begin
        word = (fmt == FMT_R) ? {funct7, rs2, rs1, funct3, rd, opcode} :
               (fmt == FMT_I) ? {imm[11:0], rs1, funct3, rd, opcode} :
               (fmt == FMT_S) ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
               (fmt == FMT_B) ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode} :
               (fmt == FMT_U) ? {imm[31:12], rd, opcode} :
                                {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
    end

    // Session control: IDLE latches the job, LOAD counts legal transfers, DONE pulses once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            addr      <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= {base_addr[31:2], 2'b00};
                        remaining <= count;
                        err       <= 1'b0;
                        state     <= (count == 16'd0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (xfer && legal) begin
                        addr      <= addr + 32'd4;
                        remaining <= remaining - 16'd1;
                    end
                    if (xfer && !legal)
                        err <= 1'b1;
                    if (remaining == 16'd0)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered write port: one write the cycle after each legal transfer, data held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= xfer && legal;
            if (xfer && legal) begin
                mem_addr  <= addr;
                mem_wdata <= word;
            end
        end
    end

`ifdef INST_ENC_CSUM_EN
    logic [31:0] csum_q;

    // Checksum moves together with mem_wdata so it already includes the word being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum_q <= '0;
        else if (state == IDLE && start)
            csum_q <= '0;
        else if (xfer && legal)
            csum_q <= csum_q ^ word;
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_inst_enc.sv
// tb_inst_enc: directed checks of the instruction encoder with hand-computed words.
module tb_inst_enc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] csum;

    int errors = 0;
    int checks = 0;

    inst_enc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rd(rd),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .csum(csum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [6:0] f7, input logic [31:0] im);
        in_valid = 1'b1;
        fmt = f; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
    endtask

    task automatic begin_session(input logic [31:0] b, input logic [15:0] c);
        start = 1'b1; base_addr = b; count = c;
        step();
        start = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_we", {31'b0, mem_we}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ready", {31'b0, in_ready}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_csum", csum, 0);
        step();
        rst_n = 1'b1;
        step();

        // add x3,x1,x2 at 0x100
        begin_session(32'h100, 16'd1);
        check("t1_busy", {31'b0, busy}, 1);
        check("t1_ready", {31'b0, in_ready}, 1);
        drive(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        step();
        in_valid = 1'b0;
        check("t1_we", {31'b0, mem_we}, 1);
        check("t1_addr", mem_addr, 32'h100);
        check("t1_wdata", mem_wdata, 32'h002081B3);
        check("t1_ready_last", {31'b0, in_ready}, 0);
        check("t1_done_early", {31'b0, done}, 0);
        step();
        check("t1_done", {31'b0, done}, 1);
        check("t1_we_off", {31'b0, mem_we}, 0);
        check("t1_hold_addr", mem_addr, 32'h100);
        check("t1_hold_data", mem_wdata, 32'h002081B3);
        step();
        check("t1_done_off", {31'b0, done}, 0);
        check("t1_idle", {31'b0, busy}, 0);

        // addi x5,x0,-1 then beq x1,x2,+8 back to back
        begin_session(32'h200, 16'd2);
        drive(3'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
        step();
        check("t2_we0", {31'b0, mem_we}, 1);
        check("t2_addr0", mem_addr, 32'h200);
        check("t2_wdata0", mem_wdata, 32'hFFF00293);
        drive(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8);
        step();
        in_valid = 1'b0;
        check("t2_we1", {31'b0, mem_we}, 1);
        check("t2_addr1", mem_addr, 32'h204);
        check("t2_wdata1", mem_wdata, 32'h00208463);
        step();
        check("t2_done", {31'b0, done}, 1);
        step();

        // address wrap with valid held high; S and U words
        begin_session(32'hFFFFFFFC, 16'd2);
        drive(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'h00000FFC);
        step();
        check("t3_addr0", mem_addr, 32'hFFFFFFFC);
        check("t3_wdata0", mem_wdata, 32'hFE20AE23);
        drive(3'd4, 7'h37, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
        step();
        in_valid = 1'b0;
        check("t3_we1", {31'b0, mem_we}, 1);
        check("t3_addr1", mem_addr, 32'h00000000);
        check("t3_wdata1", mem_wdata, 32'h123453B7);
`ifdef INST_ENC_CSUM_EN
        check("t3_csum", csum, 32'hFE20AE23 ^ 32'h123453B7);
`else
        check("t3_csum", csum, 32'h0);
`endif
        step();
        step();

        // illegal format first, then two legal words; stray start ignored
        begin_session(32'h302, 16'd2);
        drive(3'd7, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        step();
        check("t4_no_we", {31'b0, mem_we}, 0);
        check("t4_err", {31'b0, err}, 1);
        check("t4_ready", {31'b0, in_ready}, 1);
        start = 1'b1; base_addr = 32'h900; count = 16'd9;
        drive(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00000010);
        step();
        start = 1'b0;
        check("t4_we0", {31'b0, mem_we}, 1);
        check("t4_addr0", mem_addr, 32'h300);
        check("t4_wdata0", mem_wdata, 32'h010000EF);
        drive(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        step();
        in_valid = 1'b0;
        check("t4_addr1", mem_addr, 32'h304);
        check("t4_ready_last", {31'b0, in_ready}, 0);
        step();
        check("t4_done", {31'b0, done}, 1);
        check("t4_err_sticky", {31'b0, err}, 1);
        step();
        check("t4_idle", {31'b0, busy}, 0);

        // zero-count session
        begin_session(32'h400, 16'd0);
        check("t5_done", {31'b0, done}, 1);
        check("t5_we", {31'b0, mem_we}, 0);
        check("t5_err_clr", {31'b0, err}, 0);
        step();
        check("t5_done_off", {31'b0, done}, 0);

        // reset kills a pending write
        begin_session(32'h500, 16'd3);
        drive(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        check("t6_we", {31'b0, mem_we}, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_wdata", mem_wdata, 0);
        check("t6_busy", {31'b0, busy}, 0);
        check("t6_ready", {31'b0, in_ready}, 0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_we_after", {31'b0, mem_we}, 0);
        check("t6_idle_after", {31'b0, busy}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_enc.md
INST_ENC -- requirements
Module: inst_enc

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start  in  1  begin load session (sampled in IDLE only).
REQ-004 SHALL have: base_addr  in  32  first write byte address; bits [1:0] forced to 00.
REQ-005 SHALL have: count  in  16  instructions to write this session.
REQ-006 SHALL have: in_valid  in  1; in_ready  out  1  field-set handshake.
REQ-007 SHALL have: fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal.
REQ-008 SHALL have: opcode  in  7; rd  in  5; funct3  in  3; rs1  in  5; rs2  in  5; funct7  in  7; imm  in  32  instruction fields.
REQ-009 SHALL have: mem_we  out  1; mem_addr  out  32; mem_wdata  out  32  instruction-memory write port (memory always accepts).
REQ-010 SHALL have: busy  out  1; done  out  1  one-cycle pulse; err  out  1  sticky illegal-format flag.
REQ-011 SHALL have: csum  out  32  running checksum (see Configuration).

Function
REQ-012 SHALL implement states IDLE, LOAD, DONE; busy=1 in LOAD and DONE.
REQ-013 IDLE: start=1 -> latch base_addr, count; clear err and csum; go to LOAD, or to DONE if count=0.
REQ-014 in_ready SHALL be 1 only in LOAD with remaining>0; transfer occurs when in_valid&in_ready.
REQ-015 Packing SHALL be: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-016 Packing SHALL be: B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-017 Latency SHALL be exactly 1: a transfer in cycle N -> mem_we=1 for one cycle in N+1 with registered mem_addr/mem_wdata.
REQ-018 Each legal transfer SHALL decrement remaining by 1 and advance the write address by 4, wrapping modulo 2^32.
REQ-019 Illegal fmt transfer SHALL be consumed, produce no write, not decrement remaining, not advance the address, and set err.
REQ-020 Back-to-back transfers SHALL sustain one write per cycle.
REQ-021 When remaining reaches 0 -> DONE in the cycle after the last write is issued; DONE asserts done for one cycle then returns to IDLE.
REQ-022 start outside IDLE SHALL be ignored; inputs other than handshake fields ignored in LOAD.
REQ-023 mem_addr/mem_wdata SHALL hold their last values when mem_we=0.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, remaining=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, csum=0, in_ready=0, busy=0.
REQ-025 Reset mid-session SHALL abandon the session; no write may be issued after rst_n falls, including a pending one.

Configuration
REQ-026 Macro INST_ENC_CSUM_EN defined: csum SHALL be the XOR of all mem_wdata written since start, updated in the cycle mem_we=1.
REQ-027 Macro INST_ENC_CSUM_EN undefined: csum SHALL be constant 0 and no checksum register implemented.

Verification
REQ-028 start, base_addr=0x100, count=1, fmt=R add x3,x1,x2 (opcode 0x33, funct7 0) -> one cycle later mem_we=1, mem_addr=0x100, mem_wdata=0x002081B3; done pulse follows.
REQ-029 fmt=I addi x5,x0,-1 (opcode 0x13, imm 0xFFFFFFFF) -> mem_wdata=0xFFF00293; fmt=B beq x1,x2,+8 (opcode 0x63) -> 0x00208463.
REQ-030 base_addr=0xFFFFFFFC, count=2, in_valid held high -> writes at 0xFFFFFFFC then 0x00000000 on consecutive cycles, csum = XOR of both words (0 with macro undefined).
REQ-031 count=2, first transfer fmt=7 -> no write, err=1, in_ready stays 1; two legal transfers then write 0x...+0 and +4, then done.
REQ-032 count=0 -> no mem_we, done pulses within 2 cycles; rst_n low while a transfer is accepted -> no mem_we, all outputs 0, IDLE.
